// File: rtl/encoder_layer_2_attention_self_value_bias_sink.sv
// Value-bias sink: streams a bias tensor into a local buffer, then serves random reads.
// Optional macro VALUE_BIAS_SINK_CONTINUOUS_EN keeps accepting beats after the tensor is loaded.
module encoder_layer_2_attention_self_value_bias_sink #(
    parameter int VALUE_BIAS_TENSOR_SIZE_DIM_0  = 32,
    parameter int VALUE_BIAS_TENSOR_SIZE_DIM_1  = 1,
    parameter int VALUE_BIAS_PRECISION_0        = 16,
    parameter int VALUE_BIAS_PRECISION_1        = 3,
    parameter int VALUE_BIAS_PARALLELISM_DIM_0  = 1,
    parameter int VALUE_BIAS_PARALLELISM_DIM_1  = 1,
    parameter int IN_DEPTH = VALUE_BIAS_TENSOR_SIZE_DIM_0 / VALUE_BIAS_PARALLELISM_DIM_0
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [VALUE_BIAS_PRECISION_0-1:0]            data_in [VALUE_BIAS_PARALLELISM_DIM_0*VALUE_BIAS_PARALLELISM_DIM_1],
    input  logic                                         data_in_valid,
    output logic                                         data_in_ready,
    input  logic                                         reload,
    output logic                                         loaded,
    input  logic [$clog2(VALUE_BIAS_TENSOR_SIZE_DIM_0)-1:0] rd_addr,
    output logic [VALUE_BIAS_PRECISION_0-1:0]            rd_data
);

    localparam int SIZE   = VALUE_BIAS_TENSOR_SIZE_DIM_0;
    localparam int PAR    = VALUE_BIAS_PARALLELISM_DIM_0;
    localparam int CNT_W  = $clog2(IN_DEPTH) + 1;
    localparam int ADDR_W = $clog2(SIZE);

    if ((SIZE % PAR) != 0 || VALUE_BIAS_TENSOR_SIZE_DIM_1 < 1 ||
        VALUE_BIAS_PRECISION_1 >= VALUE_BIAS_PRECISION_0) begin : g_cfg_check
        $error("value bias sink: inconsistent tensor/precision parameters");
    end

    typedef enum logic {LOAD, DONE} state_t;

    state_t                            state;
    logic [CNT_W-1:0]                  beat_cnt;
    logic [VALUE_BIAS_PRECISION_0-1:0] buffer [SIZE];
    logic [ADDR_W-1:0]                 wr_addr [PAR];
    logic                              accept;
    logic                              last_beat;

`ifdef VALUE_BIAS_SINK_CONTINUOUS_EN
    assign data_in_ready = 1'b1;
`else
    assign data_in_ready = (state == LOAD);
`endif

    // A reload in the same cycle as a beat always wins; the beat is dropped.
    assign accept    = data_in_valid && data_in_ready && !reload;
    assign last_beat = (beat_cnt == CNT_W'(IN_DEPTH - 1));

    always_comb begin
        for (int j = 0; j < PAR; j++) begin
            wr_addr[j] = ADDR_W'(int'(beat_cnt) * PAR + j);
        end
    end

    // Buffer has no reset so a reload or reset only restarts the fill order.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int j = 0; j < PAR; j++) begin
                buffer[wr_addr[j]] <= data_in[j];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= LOAD;
            beat_cnt <= '0;
            loaded   <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_data <= (int'(rd_addr) < SIZE) ? buffer[rd_addr] : '0;
            case (state)
                LOAD: begin
                    if (reload) begin
                        beat_cnt <= '0;
                    end else if (accept) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            state    <= DONE;
                            loaded   <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (reload) begin
                        state    <= LOAD;
                        beat_cnt <= '0;
                        loaded   <= 1'b0;
                    end
`ifdef VALUE_BIAS_SINK_CONTINUOUS_EN
                    else if (accept) begin
                        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                    end
`endif
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: doc/encoder_layer_2_attention_self_value_bias_sink.md
ENCODER_LAYER_2_ATTENTION_SELF_VALUE_BIAS_SINK -- requirements
Module: encoder_layer_2_attention_self_value_bias_sink

Interface
REQ-001 SHALL have parameter VALUE_BIAS_TENSOR_SIZE_DIM_0, default 32, meaning total bias elements.
REQ-002 SHALL have parameter VALUE_BIAS_TENSOR_SIZE_DIM_1, default 1, meaning second tensor dimension (unused, kept for uniformity).
REQ-003 SHALL have parameter VALUE_BIAS_PRECISION_0, default 16, meaning element width in bits.
REQ-004 SHALL have parameter VALUE_BIAS_PRECISION_1, default 3, meaning fractional bits (informational only).
REQ-005 SHALL have parameter VALUE_BIAS_PARALLELISM_DIM_0, default 1, meaning elements per beat.
REQ-006 SHALL have parameter VALUE_BIAS_PARALLELISM_DIM_1, default 1, meaning second parallelism dimension.
REQ-007 SHALL have derived parameter IN_DEPTH = TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0, meaning beats per tensor.
REQ-008 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-009 SHALL have port data_in  in  array [PARALLELISM_DIM_0*PARALLELISM_DIM_1] of PRECISION_0  beat elements.
REQ-010 SHALL have ports data_in_valid  in  1  beat valid; data_in_ready  out  1  sink accepts.
REQ-011 SHALL have port reload  in  1  single-cycle request to discard buffer and reload.
REQ-012 SHALL have port loaded  out  1  full tensor held in buffer.
REQ-013 SHALL have ports rd_addr  in  $clog2(TENSOR_SIZE_DIM_0)  element index; rd_data  out  PRECISION_0  element value.

Function
REQ-014 SHALL hold a buffer of TENSOR_SIZE_DIM_0 elements, each PRECISION_0 bits.
REQ-015 SHALL implement states LOAD and DONE; data_in_ready = 1 in LOAD, 0 in DONE (see REQ-027).
REQ-016 SHALL accept a beat when data_in_valid && data_in_ready, writing data_in[j] to buffer[beat_cnt*PARALLELISM_DIM_0 + j].
REQ-017 SHALL keep beat_cnt of $clog2(IN_DEPTH)+1 bits; increment per accepted beat; on accepting beat IN_DEPTH-1 wrap to 0, go to DONE, set loaded next cycle.
REQ-018 SHALL hold beat_cnt and buffer unchanged on cycles with no accepted beat (valid low is a legal stall).
REQ-019 SHALL, on reload in DONE, go to LOAD, clear beat_cnt and loaded next cycle; buffer contents retained until overwritten.
REQ-020 SHALL, on reload in LOAD, clear beat_cnt; a beat presented the same cycle is discarded (reload wins).
REQ-021 SHALL drive rd_data registered, 1-cycle latency, from buffer[rd_addr]; rd_addr >= TENSOR_SIZE_DIM_0 returns 0.
REQ-022 SHALL return the pre-write value when rd_addr matches an element written in the same cycle.
REQ-023 SHALL keep rd_data valid in both states; consumers qualify with loaded.

Reset
REQ-024 SHALL on rst asynchronously force state LOAD, beat_cnt 0, loaded 0, rd_data 0.
REQ-025 SHALL not reset buffer contents; a reset mid-load restarts loading from beat 0.
REQ-026 SHALL drive data_in_ready 1 on the first clock after rst deasserts.

Configuration
REQ-027 SHALL support macro VALUE_BIAS_SINK_CONTINUOUS_EN: when defined, DONE keeps data_in_ready=1, accepted beats overwrite buffer via beat_cnt wrapping modulo IN_DEPTH, loaded stays 1; when undefined, behaviour is per REQ-015..REQ-020.

Verification
REQ-028 SHALL cover: reset, 32 beats values 0x0001..0x0020 valid continuous -> loaded=1 after beat 32, data_in_ready=0, rd_addr=5 gives 0x0006 one cycle later.
REQ-029 SHALL cover: 32 beats with valid low every other cycle -> identical buffer contents, loaded rises one cycle after 32nd accepted beat.
REQ-030 SHALL cover: reload pulse in DONE, then 32 beats 0x1000+i -> loaded low during load, rd_addr=31 returns 0x101F at end.
REQ-031 SHALL cover: rst asserted after 10 beats, then 32 beats 0xA000+i -> rd_addr=0 returns 0xA000, loaded set after 32 post-reset beats.
REQ-032 SHALL cover: reload and valid beat same cycle in LOAD -> beat not written, beat_cnt 0, next beat lands at index 0.
REQ-033 SHALL cover: with VALUE_BIAS_SINK_CONTINUOUS_EN, 40 beats 0x0001..0x0028 -> loaded=1, rd_addr=3 returns 0x0024, rd_addr=8 returns 0x0009.
